// File: rtl/blink_pkg.sv
// Shared mode encoding and per-channel configuration record for the LED blink array.
// Latency: n/a (types only). Backpressure: n/a.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    // Widest rate/count fields any instance may use; instances take the low bits.
    localparam int CFG_RATE_W = 5;
    localparam int CFG_CNT_W  = 16;

    typedef struct packed {
        mode_e                 mode;
        logic [CFG_RATE_W-1:0] rate;
        logic [CFG_CNT_W-1:0]  count;
    } blink_cfg_t;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: mode register, tick-driven phase counter, burst counter.
// Latency: a load shows on led/busy/done the next cycle. Backpressure: none, load always accepted.
module blink_channel
    import blink_pkg::*;
#(
    parameter int RATE_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       load_i,
    input  blink_cfg_t cfg_i,
    output logic       led_o,
    output logic       done_o,
    output logic       busy_o
);

    localparam int PH_W = (1 << RATE_W) - 1;

    mode_e             mode_q, mode_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic              led_q, led_d;
    logic              done_q, done_d;

    logic              running;
    logic [PH_W-1:0]   phase_term;
    logic              unused_cfg;

    assign unused_cfg = ^cfg_i;
    assign running    = (mode_q == MODE_BLINK) || (mode_q == MODE_BURST);
    // 2^rate - 1 as a mask: the counter is wide enough that it never wraps before matching.
    assign phase_term = {PH_W{1'b1}} >> (RATE_W'(PH_W) - rate_q);

    always_comb begin
        mode_d   = mode_q;
        rate_d   = rate_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        led_d    = led_q;
        done_d   = 1'b0;
        if (load_i) begin
            mode_d   = cfg_i.mode;
            rate_d   = cfg_i.rate[RATE_W-1:0];
            phase_d  = '0;
            remain_d = cfg_i.count[CNT_W-1:0];
            case (cfg_i.mode)
                MODE_OFF:   led_d = 1'b0;
                MODE_ON:    led_d = 1'b1;
                MODE_BLINK: led_d = 1'b1;
                MODE_BURST: begin
                    if (cfg_i.count[CNT_W-1:0] == '0) begin
                        mode_d = MODE_OFF;
                        led_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        led_d = 1'b1;
                    end
                end
                default:    led_d = 1'b0;
            endcase
        end else if (running && tick_i) begin
            if (phase_q == phase_term) begin
                phase_d = '0;
                led_d   = !led_q;
                if ((mode_q == MODE_BURST) && led_q) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == CNT_W'(1)) begin
                        mode_d = MODE_OFF;
                        led_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            rate_q   <= '0;
            phase_q  <= '0;
            remain_q <= '0;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            rate_q   <= rate_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            led_q    <= led_d;
            done_q   <= done_d;
        end
    end

    assign led_o  = led_q;
    assign done_o = done_q;
    assign busy_o = running;

endmodule

// File: rtl/blink_array.sv
// Multi-channel LED blinker: shared base-tick prescaler, write decode, NCH channels.
// Latency: writes take effect one cycle after the strobe. Backpressure: none, every write accepted.
module blink_array
    import blink_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int TICK_DIV = 100000,
    parameter int RATE_W   = 4,
    parameter int CNT_W    = 8,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_mode,
    input  logic [RATE_W-1:0] wr_rate,
    input  logic [CNT_W-1:0]  wr_count,
    output logic [NCH-1:0]    led,
    output logic [NCH-1:0]    done,
    output logic [NCH-1:0]    busy,
    output logic              tick
);

    localparam int PS_W = $clog2(TICK_DIV);

    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
    logic            tick_now;
    logic [NCH-1:0]  load;
    blink_cfg_t      cfg;

    // Free-running; writes never disturb the prescaler.
    assign tick_now = (ps_cnt_q == PS_W'(TICK_DIV - 1));
    assign ps_cnt_d = tick_now ? '0 : ps_cnt_q + 1'b1;
    assign tick     = tick_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end

    always_comb begin
        cfg                    = '0;
        cfg.mode               = mode_e'(wr_mode);
        cfg.rate[RATE_W-1:0]   = wr_rate;
        cfg.count[CNT_W-1:0]   = wr_count;
    end

    // Indices at or above NCH match no channel, so such writes fall away.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign load[c] = wr_en && (wr_ch == CH_W'(c));

        blink_channel #(
            .RATE_W (RATE_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick_i (tick_now),
            .load_i (load[c]),
            .cfg_i  (cfg),
            .led_o  (led[c]),
            .done_o (done[c]),
            .busy_o (busy[c])
        );
    end

endmodule

// File: tb/tb_blink_array.sv
// Bench for blink_array: tick-count reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_blink_array;
    import blink_pkg::*;

    localparam int NCH    = 4;
    localparam int TD     = 4;
    localparam int RATE_W = 4;
    localparam int CNT_W  = 8;
    localparam int N2     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_ch = '0;
    logic [1:0]        wr_mode = '0;
    logic [RATE_W-1:0] wr_rate = '0;
    logic [CNT_W-1:0]  wr_count = '0;
    logic [NCH-1:0]    led, done, busy;
    logic              tick;
    logic [N2-1:0]     led2, done2, busy2;
    logic              tick2;

    int     n_chk = 0;
    int     n_pass = 0;
    longint cyc;

    always #5 clk = ~clk;

    blink_array #(.NCH(NCH), .TICK_DIV(TD), .RATE_W(RATE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_rate(wr_rate), .wr_count(wr_count), .led(led), .done(done), .busy(busy), .tick(tick)
    );

    // Three-channel build sharing the write bus: writes to index 3 must be ignored by it.
    blink_array #(.NCH(N2), .TICK_DIV(TD), .RATE_W(RATE_W), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_rate(wr_rate), .wr_count(wr_count), .led(led2), .done(done2), .busy(busy2), .tick(tick2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Cycle index since reset release; the prescaler count equals cyc % TD.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Model: last accepted write per channel, outputs derived from ticks elapsed since it.
    mode_e  m_mode[NCH];
    int     m_rate[NCH];
    int     m_cnt[NCH];
    longint m_w[NCH];

    function automatic longint ticks_in(input longint a, input longint b);
        if (b < a) return 0;
        return (b + 1) / TD - a / TD;
    endfunction

    task automatic expect_ch(input int c, input longint t, output logic l, output logic b, output logic d);
        longint tg, tp, e;
        l = 1'b0; b = 1'b0; d = 1'b0;
        tg = ticks_in(m_w[c] + 1, t - 1) >> m_rate[c];
        tp = ticks_in(m_w[c] + 1, t - 2) >> m_rate[c];
        case (m_mode[c])
            MODE_ON:    l = 1'b1;
            MODE_BLINK: begin l = ~tg[0]; b = 1'b1; end
            MODE_BURST: begin
                if (m_cnt[c] == 0) begin
                    d = (t == m_w[c] + 1);
                end else begin
                    e = 2 * m_cnt[c] - 1;
                    if (tg >= e) d = (tp < e);
                    else begin l = ~tg[0]; b = 1'b1; end
                end
            end
            default: ;
        endcase
    endtask

    logic [NCH-1:0] el, eb, ed;
    logic           xl, xb, xd;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_led", longint'(led), 0);
            check("rst_busy", longint'(busy), 0);
            check("rst_done", longint'(done), 0);
            check("rst_tick", longint'(tick), 0);
            for (int c = 0; c < NCH; c++) m_mode[c] = MODE_OFF;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                expect_ch(c, cyc, xl, xb, xd);
                el[c] = xl; eb[c] = xb; ed[c] = xd;
            end
            check("led", longint'(led), longint'(el));
            check("busy", longint'(busy), longint'(eb));
            check("done", longint'(done), longint'(ed));
            check("tick", longint'(tick), longint'((cyc % TD) == TD - 1));
            check("led_n3", longint'(led2), longint'(el[N2-1:0]));
            check("busy_n3", longint'(busy2), longint'(eb[N2-1:0]));
            check("done_n3", longint'(done2), longint'(ed[N2-1:0]));
            check("tick_n3", longint'(tick2), longint'((cyc % TD) == TD - 1));
            if (wr_en) begin
                m_mode[wr_ch] = mode_e'(wr_mode);
                m_rate[wr_ch] = int'(wr_rate);
                m_cnt[wr_ch]  = int'(wr_count);
                m_w[wr_ch]    = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input mode_e m, input int r, input int n);
        wr_en    = 1'b1;
        wr_ch    = ch[1:0];
        wr_mode  = m;
        wr_rate  = r[RATE_W-1:0];
        wr_count = n[CNT_W-1:0];
        step(1);
        wr_en    = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, first_t, bad, prev, rises, falls, dones, coinc, plen, len, k;
        int tc[4];
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = MODE_OFF; m_rate[c] = 0; m_cnt[c] = 0; m_w[c] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle: tick every 4th cycle starting at cycle 3, outputs quiet.
        nt = 0; first_t = -1; bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (tick) begin nt++; if (first_t < 0) first_t = i; end
            if (led != 0 || busy != 0 || done != 0) bad++;
            step(1);
        end
        check("idle_tick_count", nt, 3);
        check("idle_first_tick", first_t, 3);
        check("idle_quiet", bad, 0);

        wr(1, MODE_ON, 0, 0);
        check("on_led1", longint'(led[1]), 1);
        check("on_busy", longint'(busy), 0);
        wr(2, MODE_OFF, 0, 0);
        check("off_led2", longint'(led[2]), 0);

        // BLINK rate 1: toggle every 2 ticks = 8 clocks.
        wr(0, MODE_BLINK, 1, 0);
        check("blink_first_led", longint'(led[0]), 1);
        check("blink_busy", longint'(busy), 1);
        prev = led[0]; nt = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (led[0] != prev[0]) begin
                if (nt < 4) tc[nt] = int'(cyc);
                nt++;
                prev = led[0];
            end
            if (!led[1] || !busy[0]) bad++;
        end
        check("blink_period", tc[2] - tc[1], 8);
        check("blink_others_steady", bad, 0);

        // BURST rate 0 count 3.
        wr(3, MODE_BURST, 0, 3);
        check("burst_first_led", longint'(led[3]), 1);
        check("burst_busy", longint'(busy[3]), 1);
        prev = 1; rises = 0; falls = 0; dones = 0; coinc = 0; plen = 0; len = 1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (done[3]) begin
                dones++;
                if (prev == 1 && !led[3]) coinc++;
            end
            if (prev == 1 && !led[3]) begin falls++; if (falls == 2) plen = len; end
            if (prev == 0 && led[3]) begin rises++; len = 0; end
            if (led[3]) len++;
            prev = led[3];
        end
        check("burst_falls", falls, 3);
        check("burst_rises", rises, 2);
        check("burst_pulse_len", plen, 4);
        check("burst_done_count", dones, 1);
        check("burst_done_on_fall", coinc, 1);
        check("burst_end_led", longint'(led[3]), 0);
        check("burst_end_busy", longint'(busy[3]), 0);

        // BURST count 0 completes immediately.
        wr(2, MODE_BURST, 2, 0);
        check("burst0_done", longint'(done[2]), 1);
        check("burst0_led", longint'(led[2]), 0);
        check("burst0_busy", longint'(busy[2]), 0);
        step(1);
        check("burst0_done_one_cycle", longint'(done[2]), 0);

        // Index 3 is out of range for the 3-channel build.
        wr(3, MODE_ON, 0, 0);
        check("oor_main_led3", longint'(led[3]), 1);
        check("oor_n3_led", longint'(led2[2:1]), 1);
        check("oor_n3_busy", longint'(busy2[2:1]), 0);

        // Asynchronous reset mid-burst.
        wr(3, MODE_BURST, 1, 5);
        check("rst_burst_led", longint'(led[3]), 1);
        step(2);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_led", longint'(led), 0);
        check("async_rst_done", longint'(done), 0);
        step(2);
        rst_n = 1'b1;

        // Rewrite coinciding with a tick: the tick is dropped, phase restarts.
        wr(3, MODE_BURST, 0, 2);
        k = 0;
        while (!tick && k < 10) begin step(1); k++; end
        check("tick_found", longint'(tick), 1);
        wr(3, MODE_BURST, 0, 2);
        check("rewrite_led", longint'(led[3]), 1);
        check("rewrite_no_done", longint'(done[3]), 0);
        len = 1; bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (done[3]) bad++;
            if (!led[3]) break;
            len++;
        end
        check("rewrite_high_len", len, 4);
        check("rewrite_no_done_window", bad, 0);

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)
                wr(int'($urandom_range(0, 3)), mode_e'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            else
                step(1);
            if (i == 1200) begin
                #2 rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
        end
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/blink_array.md
Name: blink_array

Overview:
- Parametrised multi-channel LED blink generator; successor to the single-output, fixed-rate blinker.
- A shared prescaler produces a base tick. Each channel is independently programmed with a mode, a rate and a burst count.
- Sits between the control/timekeeping logic and the board LED pins.
- Adds per-channel modes, programmable rates and counted bursts with a completion pulse.

Parameters:
- NCH, 4, number of independent output channels (1..16).
- TICK_DIV, 100000, clk cycles per base tick (1 ms at 100 MHz); must be >= 2.
- RATE_W, 4, width of the rate field; half-period = 2^rate ticks.
- CNT_W, 8, width of the burst-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  single-cycle write strobe for channel configuration.
- wr_ch  input  $clog2(NCH) (min 1)  target channel index.
- wr_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- wr_rate  input  RATE_W  half-period exponent.
- wr_count  input  CNT_W  number of on-pulses in BURST mode.
- led  output  NCH  per-channel LED drive, registered.
- done  output  NCH  one-cycle pulse when a BURST completes.
- busy  output  NCH  high while a channel is in BLINK or BURST.
- tick  output  1  one-cycle base-tick pulse, for observation.

Behaviour:
- Reset (async assert, sync release): led=0, done=0, busy=0, tick=0; all modes OFF; prescaler, phase counters and burst counters zeroed.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 during the cycle the count equals TICK_DIV-1. Free-running; never reset by writes.
- Write: sampled on a clk edge when wr_en=1. Takes effect one cycle later (registered outputs).
  - A write with wr_ch >= NCH is ignored.
  - A write always restarts the channel: phase counter=0 and mode, rate and count reloaded.
- OFF: led=0, busy=0.
- ON: led=1, busy=0.
- BLINK:
  - led=1 on the cycle after the write; busy=1.
  - On each tick, phase counter increments.
  - When phase counter = 2^rate-1 and tick=1: led toggles and phase counter returns to 0.
  - rate=0 toggles on every tick.
  - Phase counter width is 2^RATE_W-1 bits, or saturates an equivalent comparator; no wrap before the compare.
- BURST:
  - Same as BLINK, plus remaining=wr_count loaded on write.
  - Each led 1->0 transition decrements remaining.
  - The 1->0 transition that takes remaining to 0 also sets mode=OFF, busy=0 and done=1 for exactly one cycle; led stays 0.
  - wr_count=0: treated as an already-complete burst. Next cycle: led=0, busy=0, done=1 for one cycle.
- Simultaneous events:
  - A write to channel c on the same cycle as a tick: the write wins and the tick is not applied to c.
  - Other channels process that tick normally.
  - A write during an active BURST aborts it without a done pulse, unless the new write is itself BURST with count 0.
- Channels are fully independent; no cross-channel coupling other than the shared tick.
- Reset mid-burst: no done pulse is produced.

Decomposition:
- Package blink_pkg:
  - mode constants MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST (2-bit).
  - typedef for the per-channel config record {mode, rate, count}.
- Sub-module blink_channel: per-channel mode register, phase counter, burst counter, led/done/busy logic. Inputs: clk, rst_n, tick, load strobe, config.
- Top-level blink_array holds the prescaler, write decode and NCH blink_channel instances.

Test Plan (NCH=4, TICK_DIV=4, RATE_W=4, CNT_W=8):
1. Reset release, no writes -> tick pulses every 4th cycle; led=0000, busy=0000, done=0000 throughout.
2. Write ch1 ON, then ch2 OFF -> led[1]=1 one cycle after the strobe; led[2]=0; busy=0000.
3. Write ch0 BLINK rate=1 -> led[0]=1 next cycle, then toggles every 2 ticks (8 clk). busy[0]=1 continuously. Other channels are unaffected.
4. Write ch3 BURST rate=0 count=3 -> exactly 3 high pulses on led[3], each 1 tick long. done[3]=1 for one cycle coincident with the 3rd falling edge, then led[3]=0 and busy[3]=0.
5. Write ch2 BURST count=0 -> next cycle done[2]=1 for one cycle, led[2]=0. Also write wr_ch=5 (needs NCH=8 build, or drive the index when NCH=4) -> no state change.
6. Mid-BURST on ch3: assert rst_n=0 asynchronously -> led=0 immediately with no done pulse. Separately, a rewrite of ch3 coincident with tick -> phase restarts from the write and no done pulse is emitted.
